// File: rtl/prefix_subtractor_seq.sv
// prefix_subtractor_seq
// Multi-cycle subtractor: diff = a - b (mod 2^WIDTH), one CHUNK-bit slice per
// cycle, LSB slice first. Each slice evaluates a + ~b + carry through a
// Brent-Kung prefix carry network. The slice carry-out is held in a flop and
// feeds the next slice.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       minuend / subtrahend, WIDTH bits
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   diff       a - b mod 2^WIDTH
//   borrow     1 when unsigned a < b
//   zero       1 when diff == 0
//   ovf        signed two's-complement overflow
module prefix_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("prefix_subtractor_seq: WIDTH must be a multiple of CHUNK");
    end
    if ((CHUNK < 2) || (CHUNK > WIDTH) || ((CHUNK & (CHUNK - 1)) != 0)) begin : g_bad_chunk
      $error("prefix_subtractor_seq: CHUNK must be a power of two in 2..WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One slice of x + ~y + cin. Returns {carry_out, sum}.
  // The incoming carry is the generate term at position -1; it is folded into
  // bit 0 so the tree itself runs over exactly CHUNK (power-of-two) positions.
  function automatic logic [CHUNK:0] bk_slice_sub(input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y,
                                                  input logic             cin);
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] gg;
    logic [CHUNK-1:0] pp;
    logic [CHUNK-1:0] sum;
    p     = x ^ ~y;
    g     = x & ~y;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & cin);
    // Up-sweep: combine pairs at doubling distance; the top of each span
    // ends up holding the prefix of that span.
    for (int d = 1; d < CHUNK; d = d * 2) begin
      for (int i = 2 * d - 1; i < CHUNK; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i - d]);
        pp[i] = pp[i] & pp[i - d];
      end
    end
    // Down-sweep: fill in the remaining prefixes from the completed ones.
    for (int d = CHUNK / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < CHUNK; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i - d]);
        pp[i] = pp[i] & pp[i - d];
      end
    end
    sum[0] = p[0] ^ cin;
    for (int i = 1; i < CHUNK; i++) begin
      sum[i] = p[i] ^ gg[i - 1];
    end
    return {gg[CHUNK-1], sum};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDXW-1:0]  idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             zero_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CHUNK:0]   slice_res_s;
  logic [WIDTH-1:0] diff_nxt_s;

  // Current slice result and the full diff as it will look after this slice.
  always_comb begin
    slice_res_s = bk_slice_sub(a_r[int'(idx_r) * CHUNK +: CHUNK],
                               b_r[int'(idx_r) * CHUNK +: CHUNK],
                               carry_r);
    diff_nxt_s = diff_r;
    diff_nxt_s[int'(idx_r) * CHUNK +: CHUNK] = slice_res_s[CHUNK-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand, slice datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      idx_r       <= {IDXW{1'b0}};
      carry_r     <= 1'b1;
      diff_r      <= {WIDTH{1'b0}};
      borrow_r    <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            idx_r   <= {IDXW{1'b0}};
            carry_r <= 1'b1;
          end
        end
        CALC: begin
          diff_r  <= diff_nxt_s;
          carry_r <= slice_res_s[CHUNK];
          if (idx_r == LAST_IDX) begin
            // Flags come from the completed result, including this last slice.
            borrow_r <= ~slice_res_s[CHUNK];
            zero_r   <= (diff_nxt_s == {WIDTH{1'b0}});
            ovf_r    <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_nxt_s[WIDTH-1] ^ a_r[WIDTH-1]);
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign borrow    = borrow_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_prefix_subtractor_seq.sv
// Bench for prefix_subtractor_seq: two instances (CHUNK=8 and CHUNK=4, both
// WIDTH=32), a table of fixed vectors, backpressure and mid-operation reset
// sequences, and random operands checked against a - b.
module tb_prefix_subtractor_seq;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        z;
    logic        o;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid_v  [2];
  logic        in_ready_v  [2];
  logic [31:0] a_v         [2];
  logic [31:0] b_v         [2];
  logic        out_valid_v [2];
  logic        out_ready_v [2];
  logic [31:0] diff_v      [2];
  logic        borrow_v    [2];
  logic        zero_v      [2];
  logic        ovf_v       [2];

  int   n_vec;
  int   n_err;
  vec_t sb[$];
  vec_t tbl[10];

  prefix_subtractor_seq #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .diff(diff_v[0]), .borrow(borrow_v[0]), .zero(zero_v[0]), .ovf(ovf_v[0])
  );

  prefix_subtractor_seq #(.WIDTH(32), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .diff(diff_v[1]), .borrow(borrow_v[1]), .zero(zero_v[1]), .ovf(ovf_v[1])
  );

  always #5 clk = ~clk;

  function automatic vec_t model(input logic [31:0] ta, input logic [31:0] tbv);
    vec_t e;
    e.a  = ta;
    e.b  = tbv;
    e.d  = ta - tbv;
    e.br = (ta < tbv);
    e.z  = (e.d == 32'd0);
    e.o  = (ta[31] != tbv[31]) && (e.d[31] != ta[31]);
    return e;
  endfunction

  function automatic int nch_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [dut%0d] t=%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_in_ready", k, 32'(in_ready_v[k]), 32'd1);
    chk("rst_out_valid", k, 32'(out_valid_v[k]), 32'd0);
    chk("rst_diff", k, diff_v[k], 32'd0);
    chk("rst_flags", k, {29'd0, borrow_v[k], zero_v[k], ovf_v[k]}, 32'd0);
  endtask

  // One full operation on instance k; hold = cycles of out_ready=0 backpressure.
  task automatic do_op(input int k, input vec_t e, input int hold);
    vec_t got;
    int   j;
    sb.push_back(e);
    j = 0;
    while (in_ready_v[k] !== 1'b1 && j < 50) begin
      @(negedge clk);
      j++;
    end
    chk("in_ready_idle", k, 32'(in_ready_v[k]), 32'd1);
    a_v[k]         = e.a;
    b_v[k]         = e.b;
    in_valid_v[k]  = 1'b1;
    out_ready_v[k] = (hold == 0);
    @(negedge clk);
    // Scramble inputs after acceptance; result must not change.
    in_valid_v[k] = 1'b0;
    a_v[k]        = $urandom();
    b_v[k]        = $urandom();
    j = 0;
    while (out_valid_v[k] !== 1'b1 && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk("latency", k, 32'(j), 32'(nch_of(k)));
    got = sb.pop_front();
    chk("diff", k, diff_v[k], got.d);
    chk("flags{br,z,o}", k, {29'd0, borrow_v[k], zero_v[k], ovf_v[k]},
        {29'd0, got.br, got.z, got.o});
    for (int i = 0; i < hold; i++) begin
      in_valid_v[k] = 1'b1;
      a_v[k]        = $urandom();
      @(negedge clk);
      chk("hold_out_valid", k, 32'(out_valid_v[k]), 32'd1);
      chk("hold_diff", k, diff_v[k], got.d);
      chk("hold_flags", k, {29'd0, borrow_v[k], zero_v[k], ovf_v[k]},
          {29'd0, got.br, got.z, got.o});
      chk("hold_in_ready", k, 32'(in_ready_v[k]), 32'd0);
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    chk("release_out_valid", k, 32'(out_valid_v[k]), 32'd0);
    chk("release_in_ready", k, 32'(in_ready_v[k]), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b0;
      a_v[k]         = 32'd0;
      b_v[k]         = 32'd0;
    end

    tbl[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, d: 32'h0000_0002, br: 1'b0, z: 1'b0, o: 1'b0};
    tbl[1] = '{a: 32'h0000_0000, b: 32'h0000_0001, d: 32'hFFFF_FFFF, br: 1'b1, z: 1'b0, o: 1'b0};
    tbl[2] = '{a: 32'h1234_5678, b: 32'h1234_5678, d: 32'h0000_0000, br: 1'b0, z: 1'b1, o: 1'b0};
    tbl[3] = '{a: 32'h8000_0000, b: 32'h0000_0001, d: 32'h7FFF_FFFF, br: 1'b0, z: 1'b0, o: 1'b1};
    tbl[4] = '{a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, d: 32'h8000_0000, br: 1'b1, z: 1'b0, o: 1'b1};
    tbl[5] = '{a: 32'h0001_0000, b: 32'h0000_0001, d: 32'h0000_FFFF, br: 1'b0, z: 1'b0, o: 1'b0};
    tbl[6] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, d: 32'hFFFF_FFFF, br: 1'b0, z: 1'b0, o: 1'b0};
    tbl[7] = '{a: 32'h0000_0000, b: 32'h0000_0000, d: 32'h0000_0000, br: 1'b0, z: 1'b1, o: 1'b0};
    tbl[8] = '{a: 32'h8000_0000, b: 32'h8000_0000, d: 32'h0000_0000, br: 1'b0, z: 1'b1, o: 1'b0};
    tbl[9] = '{a: 32'h0000_0000, b: 32'h8000_0000, d: 32'h8000_0000, br: 1'b1, z: 1'b0, o: 1'b1};

    // Cold reset.
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed vectors on both slice widths.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) begin
        do_op(k, tbl[i], 0);
      end
    end

    // Backpressure: 10 cycles of out_ready=0 with extra in_valid.
    do_op(0, tbl[4], 10);
    do_op(1, tbl[5], 10);

    // Reset two cycles after accept; no result may appear.
    a_v[0]         = 32'h0000_00AA;
    b_v[0]         = 32'h0000_0011;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    chk_reset_vals(0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_result", 0, 32'(out_valid_v[0]), 32'd0);
    end
    do_op(0, '{a: 32'd9, b: 32'd4, d: 32'd5, br: 1'b0, z: 1'b0, o: 1'b0}, 0);

    // Random operands against a - b.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1500; i++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = $urandom();
        rb = $urandom();
        if (i % 7 == 0) begin
          rb = ra;
        end
        do_op(k, model(ra, rb), (i % 97 == 0) ? 2 : 0);
      end
    end

    chk("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
